vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Recovers pixel coordinates from a VGA hsync/vsync stream: the receiving end of the vga_controller timing interface. It lets a capture path, an on-board self-check or a second display pipeline regenerate x/y/valid without access to the generator's counters. It runs on the system clock with a per-pixel enable, tracks horizontal and vertical position, checks sync timing against parameters, and reports lock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width in pixels
- H_TOTAL, 800, pixels per line
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_TOTAL, 525, lines per frame
- SYNC_NEG, 1, 1 = sync pulses active-low
- LOCK_FRAMES, 2, clean frames in TRACK required before LOCKED

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high
- pix_en  in  1  one-cycle pixel strobe; all sampling and counting happens only on cycles with pix_en=1
- hsync  in  1  horizontal sync, polarity per SYNC_NEG
- vsync  in  1  vertical sync, polarity per SYNC_NEG
- x  out  10  recovered column, 0 when not valid
- y  out  10  recovered row, 0 when not valid
- valid  out  1  locked && h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
- locked  out  1  FSM in LOCKED
- frame_start  out  1  1-cycle pulse when valid and x=0, y=0 are first presented
- line_err  out  1  1-cycle pulse on any timing mismatch outside SEARCH

## Operation
- Sync normalisation: hs = hsync ^ SYNC_NEG and likewise vs, so 1 means asserted. hs_q and vs_q hold the previous sampled value and update only on pix_en.
- Edges: hs_rise = hs & ~hs_q, hs_fall = ~hs & hs_q; vs_rise is defined the same way. Edges are evaluated only on pix_en cycles.
- h_cnt (10b): on hs_rise, load H_ACTIVE+H_FP (656). Otherwise increment, and wrap from H_TOTAL-1 to 0. h_wrap = increment from H_TOTAL-1.
- v_cnt (10b):
  - On vs_rise, load V_ACTIVE+V_FP (490). vs_rise wins over a simultaneous h_wrap.
  - Otherwise increment on h_wrap, and wrap from V_TOTAL-1 to 0.
- Checks, active only in TRACK/LOCKED:
  - herr: hs_rise while h_cnt != 655.
  - werr: hs_fall while h_cnt != 656+H_SYNC-1 (751).
  - verr: vs_rise while v_next != 490, where v_next = h_wrap ? v_cnt+1 : v_cnt.
  - Any of these pulses line_err for one cycle.
- Watchdog (11b): counts pix_en cycles since the last hs_rise and clears on hs_rise. At 2*H_TOTAL (1600) it forces SEARCH.
- FSM states SEARCH, TRACK, LOCKED:
  - SEARCH: counters still load on edges, no checks, locked=0. First vs_rise → TRACK with good_cnt=0.
  - TRACK: vs_rise with no error since the previous vs_rise increments good_cnt. When good_cnt reaches LOCK_FRAMES → LOCKED. Any error clears good_cnt and stays in TRACK.
  - LOCKED: any error → TRACK with good_cnt=0.
  - From any state: watchdog expiry → SEARCH.
- frame_start: asserted for one cycle after the pix_en update that makes h_cnt=0, v_cnt=0 while in LOCKED.

## Timing
- Reset values:
  - Registers: state=SEARCH, h_cnt=0, v_cnt=0, good_cnt=0, watchdog=0, hs_q=vs_q=0.
  - Outputs: x=y=0, valid=0, locked=0, frame_start=0, line_err=0.
- Reset has priority over pix_en and aborts any state, mid-frame included.
- Latency: sync sampled on pix_en cycle N → h_cnt/v_cnt/state updated at cycle N+1. x/y/valid/locked are decoded from those registers with no extra stage, so they also change at N+1.
- line_err and frame_start are registered. They are high exactly during cycle N+1 and low at N+2, regardless of pix_en.
- pix_en=0: all counters, edge flops, FSM and outputs hold, except the single-cycle pulses, which clear.
- A stream with an hsync phase other than the parameters never reaches LOCKED; herr fires every line.

## Test plan
- Clean 640x480 stream, pix_en every 4th clk, SEARCH start → locked rises on the 3rd vs_rise. The next frame gives exactly 307200 valid pix_en cycles, x runs 0..639, y runs 0..479, one frame_start per frame, line_err never high.
- One hs_rise 1 pixel early while LOCKED → one line_err pulse and locked=0 at N+1; relock on the 2nd subsequent clean vs_rise.
- hsync pulse of 95 pixels → werr line_err pulse; 96 pixels → no pulse.
- hsync held deasserted for 1600 pix_en cycles → SEARCH, locked=0, valid=0; normal stream restored → relock after 3 vs_rise edges.
- reset asserted mid-frame while LOCKED at x=320, y=200 → next cycle all outputs 0 and state SEARCH.
- pix_en held low for 100 clk mid-line at x=100 while hsync toggles → x stays 100, no edge detected, no line_err; resumes at x=101.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers x/y/valid and lock status from a VGA hsync/vsync stream
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_TOTAL     = 800,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_TOTAL     = 525,
  parameter bit SYNC_NEG    = 1'b1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       valid,
  output logic       locked,
  output logic       frame_start,
  output logic       line_err
);

  localparam logic [9:0]  H_LOAD    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  H_RISE_AT = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0]  H_FALL_AT = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_LOAD    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [10:0] WD_LAST   = 11'(2 * H_TOTAL - 1);
  localparam int          GW        = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [GW-1:0] good_cnt, good_next, good_inc;

  logic          hs, vs, hs_q, vs_q;
  logic          hs_rise, hs_fall, vs_rise;
  logic [9:0]    h_cnt, v_cnt, h_next, v_line, v_next;
  logic          h_wrap;
  logic          checking, herr, werr, verr, timing_err;
  logic [10:0]   wd_cnt;
  logic          wd_expire;

  // Normalised syncs: 1 always means "pulse asserted".
  assign hs      = hsync ^ SYNC_NEG;
  assign vs      = vsync ^ SYNC_NEG;
  assign hs_rise = hs & ~hs_q;
  assign hs_fall = ~hs & hs_q;
  assign vs_rise = vs & ~vs_q;

  always_comb begin
    h_wrap = ~hs_rise && (h_cnt == H_LAST);
    if (hs_rise) begin
      h_next = H_LOAD;
    end else if (h_wrap) begin
      h_next = '0;
    end else begin
      h_next = h_cnt + 10'd1;
    end
    v_line = v_cnt;
    if (h_wrap) begin
      v_line = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
    v_next = vs_rise ? V_LOAD : v_line;
  end

  // A vsync edge must land on the line the counters are about to enter.
  always_comb begin
    checking   = (state != SEARCH);
    herr       = hs_rise && (h_cnt != H_RISE_AT);
    werr       = hs_fall && (h_cnt != H_FALL_AT);
    verr       = vs_rise && (v_line != V_LOAD);
    timing_err = checking && (herr || werr || verr);
    wd_expire  = ~hs_rise && (wd_cnt == WD_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
      wd_cnt <= '0;
    end else if (pix_en) begin
      hs_q   <= hs;
      vs_q   <= vs;
      h_cnt  <= h_next;
      v_cnt  <= v_next;
      wd_cnt <= (hs_rise || wd_expire) ? '0 : wd_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else if (pix_en) begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  assign good_inc = good_cnt + GW'(1);

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    if (wd_expire) begin
      state_next = SEARCH;
      good_next  = '0;
    end else begin
      case (state)
        SEARCH: begin
          if (vs_rise) begin
            state_next = TRACK;
            good_next  = '0;
          end
        end
        TRACK: begin
          if (timing_err) begin
            good_next = '0;
          end else if (vs_rise) begin
            good_next = good_inc;
            if (good_inc == GOOD_LOCK) begin
              state_next = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (timing_err) begin
            state_next = TRACK;
            good_next  = '0;
          end
        end
        default: begin
          state_next = SEARCH;
          good_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
    valid  = locked && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    x      = valid ? h_cnt : '0;
    y      = valid ? v_cnt : '0;
  end

  // Pulses are qualified by pix_en so they last exactly one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_next == '0) && (v_next == '0) && (state_next == LOCKED);
      line_err    <= pix_en && timing_err;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - randomized self-checking bench for vga_sync_decoder
module tb_vga_sync_decoder;

  localparam int HA = 16, HF = 4, HS = 6, HT = 32;
  localparam int VA = 8, VF = 2, VT = 14, LF = 2;
  localparam bit SN = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] x, y;
  logic       valid, locked, frame_start, line_err;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VF), .V_TOTAL(VT), .SYNC_NEG(SN), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .valid(valid), .locked(locked),
    .frame_start(frame_start), .line_err(line_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0=search, 1=track, 2=locked
  int m_state = 0, m_h = 0, m_v = 0, m_good = 0, m_wd = 0;
  bit m_hsq = 0, m_vsq = 0, m_fs = 0, m_le = 0, m_pe = 0;

  always @(posedge clk) begin
    bit hs, vs, hr, hf, vr, wrap, err, expire;
    int nh, nv, vline, ns;
    m_fs = 0;
    m_le = 0;
    m_pe = pix_en && !reset;
    if (reset) begin
      m_state = 0; m_h = 0; m_v = 0; m_good = 0; m_wd = 0; m_hsq = 0; m_vsq = 0;
    end else if (pix_en) begin
      hs = hsync ^ SN;
      vs = vsync ^ SN;
      hr = hs && !m_hsq;
      hf = !hs && m_hsq;
      vr = vs && !m_vsq;
      wrap = !hr && (m_h == HT - 1);
      nh = hr ? HA + HF : (m_h + 1) % HT;
      vline = wrap ? (m_v + 1) % VT : m_v;
      nv = vr ? VA + VF : vline;
      err = (m_state != 0) && ((hr && m_h != HA + HF - 1) ||
                               (hf && m_h != HA + HF + HS - 1) ||
                               (vr && vline != VA + VF));
      expire = 0;
      if (hr) m_wd = 0;
      else begin
        m_wd++;
        if (m_wd == 2 * HT) begin expire = 1; m_wd = 0; end
      end
      ns = m_state;
      if (expire) begin ns = 0; m_good = 0; end
      else if (m_state == 0) begin if (vr) begin ns = 1; m_good = 0; end end
      else if (err) begin ns = 1; m_good = 0; end
      else if (vr && m_state == 1) begin
        m_good++;
        if (m_good >= LF) ns = 2;
      end
      m_fs = (nh == 0) && (nv == 0) && (ns == 2);
      m_le = err;
      m_h = nh; m_v = nv; m_state = ns; m_hsq = hs; m_vsq = vs;
    end
  end

  int t_valid = 0, t_fs = 0, t_le = 0, t_maxx = 0, t_maxy = 0;

  always @(negedge clk) begin
    bit ev;
    ev = (m_state == 2) && (m_h < HA) && (m_v < VA);
    check("valid", int'(valid), int'(ev));
    check("locked", int'(locked), int'(m_state == 2));
    check("x", int'(x), ev ? m_h : 0);
    check("y", int'(y), ev ? m_v : 0);
    check("frame_start", int'(frame_start), int'(m_fs));
    check("line_err", int'(line_err), int'(m_le));
    if (m_pe && valid) begin
      t_valid++;
      if (int'(x) > t_maxx) t_maxx = int'(x);
      if (int'(y) > t_maxy) t_maxy = int'(y);
    end
    if (frame_start) t_fs++;
    if (line_err) t_le++;
  end

  // Stream generator
  int g_h = 0, g_v = 0, hs_width = HS, vs_rises = 0;
  bit hs_off = 0, vs_off = 0, prev_vs = 0;

  task automatic send_pix();
    bit ha, va;
    ha = !hs_off && (g_h >= HA + HF) && (g_h < HA + HF + hs_width);
    va = !vs_off && (g_v >= VA + VF) && (g_v < VA + VF + 2);
    if (va && !prev_vs) vs_rises++;
    prev_vs = va;
    hsync = ~ha;
    vsync = ~va;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      @(posedge clk); #1;
    end
    g_h++;
    if (g_h == HT) begin
      g_h = 0;
      g_v = (g_v + 1) % VT;
    end
  endtask

  task automatic run_to(input int v, input int h);
    for (int i = 0; i < HT * VT + 1; i++) begin
      if (g_v == v && g_h == h) break;
      send_pix();
    end
  endtask

  task automatic run_until_locked(output int rises);
    vs_rises = 0;
    for (int i = 0; i < 6 * HT * VT; i++) begin
      if (locked) break;
      send_pix();
    end
    check("lock_within_budget", int'(locked), 1);
    rises = vs_rises;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL timeout: got running, expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int rises;
    repeat (3) @(posedge clk);
    #1;
    check("reset_x", int'(x), 0);
    check("reset_y", int'(y), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_line_err", int'(line_err), 0);
    reset = 1'b0;

    // Clean stream from SEARCH
    t_le = 0;
    run_until_locked(rises);
    check("rises_to_first_lock", rises, 3);
    check("no_err_while_locking", t_le, 0);
    t_valid = 0; t_fs = 0; t_le = 0; t_maxx = 0; t_maxy = 0;
    repeat (HT * VT) send_pix();
    check("valid_pixels_per_frame", t_valid, HA * VA);
    check("frame_starts_per_frame", t_fs, 1);
    check("line_err_clean_frame", t_le, 0);
    check("max_x", t_maxx, HA - 1);
    check("max_y", t_maxy, VA - 1);
    check("still_locked", int'(locked), 1);

    // One hs_rise a pixel early (one short line)
    run_to(3, HA + HF - 1);
    g_h = HA + HF;
    t_le = 0;
    send_pix();
    check("early_hs_unlocks", int'(locked), 0);
    check("early_hs_one_err", t_le, 1);
    run_until_locked(rises);
    check("rises_to_relock_after_err", rises, 2);
    check("early_hs_total_errs", t_le, 1);

    // Short hsync pulse, then nominal pulse
    run_to(2, 0);
    hs_width = HS - 1;
    t_le = 0;
    repeat (HT) send_pix();
    check("short_pulse_err", t_le, 1);
    check("short_pulse_unlocks", int'(locked), 0);
    hs_width = HS;
    t_le = 0;
    repeat (HT) send_pix();
    check("nominal_pulse_no_err", t_le, 0);
    run_until_locked(rises);
    check("rises_to_relock_after_werr", rises, 2);

    // Watchdog: syncs held deasserted
    run_to(0, 0);
    check("locked_before_hold", int'(locked), 1);
    hs_off = 1; vs_off = 1;
    repeat (3 * HT) send_pix();
    check("hold_unlocks", int'(locked), 0);
    check("hold_invalid", int'(valid), 0);
    hs_off = 0; vs_off = 0;
    run_until_locked(rises);
    check("rises_to_relock_after_watchdog", rises, 3);

    // Reset mid-frame while locked
    run_to(VA / 2, HA / 2);
    send_pix();
    check("pre_reset_x", int'(x), HA / 2);
    check("pre_reset_y", int'(y), VA / 2);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_x", int'(x), 0);
    check("midreset_y", int'(y), 0);
    check("midreset_valid", int'(valid), 0);
    check("midreset_locked", int'(locked), 0);
    check("midreset_line_err", int'(line_err), 0);
    reset = 1'b0;
    run_until_locked(rises);
    check("rises_to_relock_after_reset", rises, 3);

    // pix_en held low with sync noise
    run_to(2, 5);
    send_pix();
    check("pre_stall_x", int'(x), 5);
    t_le = 0;
    repeat (100) begin
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      @(posedge clk); #1;
    end
    check("stall_x_holds", int'(x), 5);
    check("stall_no_err", t_le, 0);
    check("stall_locked", int'(locked), 1);
    send_pix();
    check("resume_x", int'(x), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
